// File: rtl/mc_controller.sv
// Multicycle RV32I control unit: Moore FSM sequencing one instruction at a time,
// with branch resolution from the live ALU flags in the BRANCH state.
module mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       overflow,
  input  logic       carry,
  input  logic       negative,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [3:0] ALUControl,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_EXECUTEI = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_JALR     = 4'd11;
  localparam logic [3:0] S_JALRWB   = 4'd12;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  logic [3:0] state_r;
  logic [3:0] next_state_s;

  // Sub is only legal on the register form; addi with IR[30] set is still add.
  function automatic logic [3:0] alu_decode(input logic op5, input logic [2:0] f3,
                                            input logic f7b5);
    logic [3:0] ctl;
    case (f3)
      3'b000:  ctl = (op5 & f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  ctl = ALU_SLL;
      3'b010:  ctl = ALU_SLT;
      3'b011:  ctl = ALU_SLTU;
      3'b100:  ctl = ALU_XOR;
      3'b101:  ctl = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  ctl = ALU_OR;
      3'b111:  ctl = ALU_AND;
      default: ctl = ALU_ADD;
    endcase
    return ctl;
  endfunction

  // Flags come from rs1 - rs2; carry set means no borrow (rs1 >= rs2 unsigned).
  function automatic logic branch_taken(input logic [2:0] f3, input logic z,
                                        input logic n, input logic v, input logic c);
    logic tk;
    case (f3)
      3'b000:  tk = z;
      3'b001:  tk = ~z;
      3'b100:  tk = n ^ v;
      3'b101:  tk = ~(n ^ v);
      3'b110:  tk = ~c;
      3'b111:  tk = c;
      default: tk = 1'b0;
    endcase
    return tk;
  endfunction

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic
  always_comb begin
    next_state_s = S_FETCH;
    case (state_r)
      S_FETCH:    next_state_s = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: next_state_s = S_MEMADR;
          OP_RTYPE:          next_state_s = S_EXECUTER;
          OP_ITYPE:          next_state_s = S_EXECUTEI;
          OP_BRANCH:         next_state_s = S_BRANCH;
          OP_JAL:            next_state_s = S_JAL;
          OP_JALR:           next_state_s = S_JALR;
          default:           next_state_s = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (op[5]) begin
          next_state_s = S_MEMWRITE;
        end else begin
          next_state_s = S_MEMREAD;
        end
      end
      S_MEMREAD:  next_state_s = S_MEMWB;
      S_MEMWB:    next_state_s = S_FETCH;
      S_MEMWRITE: next_state_s = S_FETCH;
      S_EXECUTER: next_state_s = S_ALUWB;
      S_EXECUTEI: next_state_s = S_ALUWB;
      S_ALUWB:    next_state_s = S_FETCH;
      S_BRANCH:   next_state_s = S_FETCH;
      S_JAL:      next_state_s = S_ALUWB;
      S_JALR:     next_state_s = S_JALRWB;
      S_JALRWB:   next_state_s = S_FETCH;
      default:    next_state_s = S_FETCH;
    endcase
  end

  // Output decode from current state (and flags in BRANCH)
  always_comb begin
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ImmSrc     = 2'b00;
    ALUControl = ALU_ADD;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (state_r)
      S_FETCH: begin
        IRWrite   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        PCWrite   = 1'b1;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = (op == OP_JAL) ? IMM_J : IMM_B;
        case (op)
          OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE,
          OP_BRANCH, OP_JAL, OP_JALR: begin
            illegal    = 1'b0;
            instr_done = 1'b0;
          end
          default: begin
            illegal    = 1'b1;
            instr_done = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ImmSrc  = op[5] ? IMM_S : IMM_I;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc  = 2'b01;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc     = 1'b1;
        MemWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA    = 2'b10;
        ALUControl = alu_decode(op[5], funct3, funct7b5);
      end
      S_EXECUTEI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ImmSrc     = IMM_I;
        ALUControl = alu_decode(op[5], funct3, funct7b5);
      end
      S_ALUWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUControl = ALU_SUB;
        instr_done = 1'b1;
        PCWrite    = branch_taken(funct3, Zero, negative, overflow, carry);
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
      end
      S_JALR: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ImmSrc    = IMM_I;
        ResultSrc = 2'b10;
        PCWrite   = 1'b1;
      end
      S_JALRWB: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      default: begin
        PCWrite = 1'b0;
      end
    endcase
  end

  assign state = state_r;

endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle control unit for the RV32I core. A Moore FSM with a branch-resolution overlay drives every datapath select and enable, one instruction at a time. It replaces the single-cycle `maindec`/`aludec` pair when the core moves to a shared instruction/data memory with IR, OldPC, A, WriteData, Data and ALUOut holding registers. ALUControl encodings and ALU flag semantics are unchanged from the single-cycle core.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- reset  in  1  reset reset, asynchronous, active-high; clock clk
- op  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- funct7b5  in  1  IR[30]
- Zero, overflow, carry, negative  in  1 each  ALU flags from the current-cycle ALU result
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address: 0=PC, 1=Result
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  IR and OldPC enable
- RegWrite  out  1  register-file write enable
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
- ALUSrcA  out  2  00=PC, 01=OldPC, 10=A
- ALUSrcB  out  2  00=WriteData, 01=ImmExt, 10=constant 4
- ImmSrc  out  2  00=I, 01=S, 10=B, 11=J
- ALUControl  out  4  0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sll, 0111 srl, 1000 sltu, 1001 sra
- state  out  4  current state code, for debug and bench
- instr_done  out  1  one-cycle pulse in the final cycle of each instruction
- illegal  out  1  one-cycle pulse in DECODE for an unsupported opcode

## Operation
- State codes: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9, JAL=10, JALR=11, JALRWB=12. Codes 13–15 are unreachable; if entered, go to FETCH.
- Outputs not listed for a state are 0, except ImmSrc, ALUControl and the select fields, which hold their defaults of 0.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10, PCWrite=1. Next state: DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, add; ImmSrc=B, or J when op=1101111. This captures OldPC+imm in ALUOut. Next state by op:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECUTER
  - 0010011 → EXECUTEI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR
  - any other op → FETCH, with illegal=1 and instr_done=1
- MEMADR: ALUSrcA=10, ALUSrcB=01, add; ImmSrc=S if op[5]=1, else I. Next: MEMWRITE if op[5]=1, else MEMREAD.
- MEMREAD: ResultSrc=00, AdrSrc=1. Next: MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, instr_done=1. Next: FETCH.
- MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1, instr_done=1. Next: FETCH.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, funct-decoded ALUControl. Next: ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ImmSrc=I, funct-decoded ALUControl. Next: ALUWB.
- Funct decode:
  - funct3 000: sub when (op[5] & funct7b5), else add
  - funct3 101: sra when funct7b5, else srl
  - others follow the funct3 → ALUControl map above
- ALUWB: ResultSrc=00, RegWrite=1, instr_done=1. Next: FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, instr_done=1. PCWrite=taken, resolved per funct3:
  - beq: Zero
  - bne: ~Zero
  - blt: negative^overflow
  - bge: ~(negative^overflow)
  - bltu: ~carry
  - bgeu: carry
  - funct3 010/011: not taken

  Next: FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1. This sets PC from ALUOut (the DECODE target) and captures OldPC+4 into ALUOut. Next: ALUWB.
- JALR: ALUSrcA=10, ALUSrcB=01, ImmSrc=I, add, ResultSrc=10, PCWrite=1, so PC=rs1+imm. Bit-0 clearing is done in the datapath, not here. Next: JALRWB.
- JALRWB: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=10, RegWrite=1, instr_done=1. Next: FETCH.

## Timing
- Reset is asynchronous: state becomes FETCH immediately and outputs take FETCH values combinationally. The datapath registers are held reset at the same time, so PCWrite=1 during reset is harmless. First fetch occurs on the first rising edge after reset deasserts.
- Reset asserted mid-instruction: state returns to FETCH at once, and no partial MemWrite or RegWrite is asserted after the assertion point.
- All outputs are combinational from state, op, funct3, funct7b5 and the flags. PCWrite in BRANCH is the only flag-dependent output.
- State advances on each rising clk. There are no stall inputs.
- Latency in cycles, including FETCH:
  - lw: 5
  - sw: 4
  - R-type, I-type ALU: 4
  - branch: 3
  - jal: 4
  - jalr: 4
  - illegal: 2
- instr_done is high in exactly one cycle per instruction, always the cycle immediately before FETCH.

## Test plan
- Reset held 2 cycles mid-MEMREAD, then released → state=0 during reset; IRWrite=1, PCWrite=1; state=1 after the first edge.
- add, then sub (funct7b5=1), then sra (funct3=101, funct7b5=1) → ALUControl in EXECUTER = 0000, 0001, 1001 respectively; RegWrite=1 only in ALUWB; instr_done seen 3 times in 12 cycles.
- lw, then sw → state sequence 0,1,2,3,4 then 0,1,2,5; MemWrite=1 only in state 5; AdrSrc=1 in states 3 and 5.
- Branches with Zero=1,negative=0,overflow=0,carry=1 in BRANCH → PCWrite: beq 1, bne 0, blt 0, bge 1, bltu 0, bgeu 1.
- jal, then jalr → states 0,1,10,8 and 0,1,11,12; PCWrite=1 in states 10 and 11; RegWrite=1 in states 8 and 12.
- op=0110111 (lui, unsupported) → illegal=1 and instr_done=1 in DECODE; next state=0; no RegWrite, MemWrite or PCWrite after FETCH.
